match_ctl: RTL
==============

MATCH_CTL -- requirements
Module: match_ctl

Interface
REQ-001 Parameter WIN_SCORE, default 3, points needed to win (legal range 1..3).
REQ-002 Parameter SERVE_FRAMES, default 60, frame ticks spent in SERVE before the ball is launched (legal range 1..255).
REQ-003 Parameter POINT_FRAMES, default 90, frame ticks spent in POINT after a score (legal range 1..255).
REQ-004 clk  input  1  pixel clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 vsync_in  input  1  VGA vsync from the timing chain; its rising edge defines one frame tick.
REQ-007 start  input  1  start/restart request, level; only its rising edge SHALL act.
REQ-008 pause  input  1  pause toggle request, level; only its rising edge SHALL act.
REQ-009 point_p1 / point_p2  input  1 each  one-cycle pulses from the ball controller: player 1 / player 2 scored.
REQ-010 ball_run  output  1  high only in PLAY; ball controller moves the ball only while high.
REQ-011 ball_serve  output  1  one-cycle pulse: re-centre and launch the ball.
REQ-012 serve_dir  output  1  launch direction; 0 = toward player 2, 1 = toward player 1.
REQ-013 score_p1 / score_p2  output  2 each  current scores, consumed by the score renderer and segment display.
REQ-014 winner  output  2  00 none, 01 player 1, 10 player 2.
REQ-015 state  output  3  current state encoding, from the shared package.

Function
REQ-016 start, pause and vsync_in SHALL each be registered once; an edge is detected as current=1 and previous=0, one cycle after the input changes.
REQ-017 States: IDLE, SERVE, PLAY, POINT, OVER, PAUSE.
REQ-018 A single 8-bit frame counter SHALL be cleared on every state entry and increment on each frame tick while in SERVE or POINT.
REQ-019 IDLE: on a start edge, clear both scores, clear winner, set serve_dir=0, and go to SERVE.
REQ-020 SERVE: on the frame tick that brings the counter to SERVE_FRAMES, go to PLAY and assert ball_serve for exactly that cycle.
REQ-021 PLAY, point_p1: score_p1 increments, serve_dir becomes 1, next state POINT.
REQ-022 PLAY, point_p2: score_p2 increments, serve_dir becomes 0, next state POINT.
REQ-023 PLAY, point_p1 and point_p2 in the same cycle: point_p1 SHALL win; point_p2 is dropped.
REQ-024 point pulses outside PLAY SHALL be ignored.
REQ-025 POINT: on the frame tick that brings the counter to POINT_FRAMES, go to OVER if either score equals WIN_SCORE, else to SERVE.
REQ-026 On entry to OVER, winner SHALL identify the player whose score equals WIN_SCORE.
REQ-027 OVER: scores and winner hold; a start edge behaves as in IDLE (clear, then SERVE).
REQ-028 A start edge in SERVE, PLAY, POINT or PAUSE SHALL be ignored.
REQ-029 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-030 Outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-031 rst SHALL force IDLE in any state, including mid-count.
REQ-032 rst values: ball_run=0, ball_serve=0, serve_dir=0, scores=0, winner=00, frame counter=0, all edge-detect history=0.

Configuration
REQ-033 Macro MATCH_CTL_PAUSE_EN.
REQ-034 With MATCH_CTL_PAUSE_EN defined: a pause edge in PLAY SHALL go to PAUSE with ball_run=0. A pause edge in PAUSE SHALL return to PLAY without pulsing ball_serve. Point pulses in PAUSE SHALL be ignored.
REQ-035 Without MATCH_CTL_PAUSE_EN: the pause input is unused and the PAUSE state is unreachable.

Structure
REQ-036 The state encoding, winner encoding and score width constant SHALL live in the shared package game_pkg.
REQ-037 One sub-module, edge_det (one-bit register plus rising-edge detector), SHALL be instantiated three times: vsync_in, start, pause.

Verification
Use WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2 for all scenarios.
REQ-038 rst, then start edge -> state SERVE; after 2 vsync rises, exactly one ball_serve pulse, ball_run=1, state PLAY.
REQ-039 In PLAY, point_p2 pulse -> score_p2=1, serve_dir=0, POINT; after 2 ticks -> SERVE, then PLAY with ball_serve.
REQ-040 Three point_p1 rounds -> score_p1=3, OVER, winner=01; further point pulses ignored; start edge -> scores 0, SERVE.
REQ-041 Simultaneous point_p1 and point_p2 in PLAY -> score_p1 +1, score_p2 unchanged.
REQ-042 rst asserted in POINT with counter=1 -> next cycle IDLE with all REQ-032 values.
REQ-043 With MATCH_CTL_PAUSE_EN defined: pause edge in PLAY -> PAUSE, ball_run=0; point_p2 is ignored; second pause edge -> PLAY, no ball_serve. Without the macro: pause edges have no effect.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, winner encoding, score width
// and a saturating score increment.
package game_pkg;

  localparam int SCORE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/match_ctl_edge_det.sv
// One-bit input register followed by a rising-edge detector; the edge is
// reported one cycle after the input changes.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic cur_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= d_i;
      prev_q <= cur_q;
    end
  end

  assign rise_o = cur_q & ~prev_q;

endmodule

// File: rtl/match_ctl.sv
// Match sequencing FSM: serve, play, point hold and game-over with scoring.
// Optional pause support is built when MATCH_CTL_PAUSE_EN is defined.
module match_ctl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync_in,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 point_p1,
  input  logic                 point_p2,
  output logic                 ball_run,
  output logic                 ball_serve,
  output logic                 serve_dir,
  output logic [SCORE_W-1:0]   score_p1,
  output logic [SCORE_W-1:0]   score_p2,
  output logic [1:0]           winner,
  output logic [2:0]           state
);

  localparam logic [SCORE_W-1:0] WIN_N   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_N = 8'(SERVE_FRAMES);
  localparam logic [7:0]         POINT_N = 8'(POINT_FRAMES);

  logic tick, start_edge, pause_edge;

  edge_det u_vsync (.clk(clk), .rst(rst), .d_i(vsync_in), .rise_o(tick));
  edge_det u_start (.clk(clk), .rst(rst), .d_i(start),    .rise_o(start_edge));
  edge_det u_pause (.clk(clk), .rst(rst), .d_i(pause),    .rise_o(pause_edge));

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [1:0]           winner_q, winner_d;
  logic                 serve_dir_q, serve_dir_d;
  logic                 ball_serve_q, ball_serve_d;
  logic                 ball_run_q, ball_run_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      winner_q     <= WIN_NONE;
      serve_dir_q  <= 1'b0;
      ball_serve_q <= 1'b0;
      ball_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      ball_serve_q <= ball_serve_d;
      ball_run_q   <= ball_run_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    ball_serve_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          score_p1_d  = '0;
          score_p2_d  = '0;
          winner_d    = WIN_NONE;
          serve_dir_d = 1'b0;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == SERVE_N) begin
            state_d      = ST_PLAY;
            ball_serve_d = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // Player 1 has priority when both players score in the same cycle.
        if (point_p1) begin
          score_p1_d  = sat_inc(score_p1_q, WIN_N);
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end else if (point_p2) begin
          score_p2_d  = sat_inc(score_p2_q, WIN_N);
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end
`ifdef MATCH_CTL_PAUSE_EN
        else if (pause_edge) begin
          state_d = ST_PAUSE;
        end
`endif
      end
      ST_POINT: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == POINT_N) begin
            if (score_p1_q == WIN_N || score_p2_q == WIN_N) begin
              state_d  = ST_OVER;
              winner_d = (score_p1_q == WIN_N) ? WIN_P1 : WIN_P2;
            end else begin
              state_d = ST_SERVE;
            end
          end
        end
      end
      // Only reachable when pause support is built in.
      ST_PAUSE: begin
        if (pause_edge) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
    ball_run_d = (state_d == ST_PLAY);
  end

  assign ball_run   = ball_run_q;
  assign ball_serve = ball_serve_q;
  assign serve_dir  = serve_dir_q;
  assign score_p1   = score_p1_q;
  assign score_p2   = score_p2_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule
